// File: rtl/uart_reg_bridge.sv
// UART-slave register bridge: decodes 3-byte command headers on rxd, performs
// single/burst read/write on 16 x 16-bit registers, answers on txd.
module uart_reg_bridge #(
  parameter logic [3:0] BASEADDR = 4'h0,
  parameter int         BAUD_DIV = 16,
  parameter int         TIMEOUT  = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic parity_en,
  input  logic rxd,
  output logic txd,
  output logic busy,
  output logic err
);
  localparam int            BW       = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BIT_END  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_END = BW'(BAUD_DIV / 2 - 1);
  localparam int            IW       = $clog2((TIMEOUT + 12) * BAUD_DIV + 1);
  localparam logic [IW-1:0] TO_CYC   = IW'(TIMEOUT * BAUD_DIV);
  localparam logic [IW-1:0] BYTE_N1  = IW'(10 * BAUD_DIV);
  localparam logic [IW-1:0] BYTE_E1  = IW'(11 * BAUD_DIV);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_st_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP} tx_st_t;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WDATA, S_RESP, S_ACK, S_RECOV} st_t;

  // ---------------- rx synchroniser / parity mode ----------------
  logic rx_m, rx_s, par_mode;
  st_t  st, st_nx;
  logic rx_en, tx_go, reg_we;
  logic [7:0] tx_byte;

  // two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk) begin
    if (rst) {rx_s, rx_m} <= 2'b11;
    else     {rx_s, rx_m} <= {rx_m, rxd};
  end

  // ---------------- receiver ----------------
  rx_st_t        rx_st;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_perr, rx_done, rx_bad;

  // start detect, mid-bit recentre, then one sample per bit-time
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st <= R_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0;
      rx_perr <= 1'b0; rx_done <= 1'b0; rx_bad <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_bad  <= 1'b0;
      rx_cnt  <= rx_cnt + BW'(1);
      case (rx_st)
        R_IDLE: begin
          rx_cnt  <= '0;
          rx_perr <= 1'b0;
          if (rx_en && !rx_s) rx_st <= R_START;
        end
        R_START: if (rx_cnt == HALF_END) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s ? R_IDLE : R_DATA;   // high at mid-point: glitch
        end
        R_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= par_mode ? R_PAR : R_STOP;
        end
        R_PAR: if (rx_cnt == BIT_END) begin
          rx_cnt  <= '0;
          rx_perr <= rx_s ^ (^rx_sh);
          rx_st   <= R_STOP;
        end
        R_STOP: if (rx_cnt == BIT_END) begin
          rx_done <= 1'b1;
          rx_bad  <= rx_perr | ~rx_s;
          rx_st   <= R_IDLE;
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  tx_st_t        tx_st;
  logic [BW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [10:0]   tx_sh;
  logic          tx_done;

  // frame shifter; tx_done at end of stop bit, then one idle bit-time of gap
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= T_IDLE; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '1; tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_cnt  <= tx_cnt + BW'(1);
      case (tx_st)
        T_IDLE: begin
          tx_cnt <= '0;
          if (tx_go) begin
            tx_sh  <= {1'b1, par_mode ? ^tx_byte : 1'b1, tx_byte, 1'b0};
            tx_bit <= '0;
            tx_st  <= T_SEND;
          end
        end
        T_SEND: if (tx_cnt == BIT_END) begin
          tx_cnt <= '0;
          tx_sh  <= {1'b1, tx_sh[10:1]};
          tx_bit <= tx_bit + 4'd1;
          if (tx_bit == (par_mode ? 4'd10 : 4'd9)) begin
            tx_done <= 1'b1;
            tx_st   <= T_GAP;
          end
        end
        T_GAP: if (tx_cnt == BIT_END) tx_st <= T_IDLE;
        default: tx_st <= T_IDLE;
      endcase
    end
  end

  assign txd = (tx_st == T_SEND) ? tx_sh[0] : 1'b1;

  // ---------------- command FSM ----------------
  logic [1:0]    hcnt;
  logic          rw, hb;
  logic [3:0]    len, blk, idx, wcnt, ridx;
  logic [7:0]    hold;
  logic [15:0]   rd_word;
  logic [15:0]   regs [16];
  logic [IW-1:0] idle_cnt;
  logic          hit, last_word, timeout, good_byte, bad_byte;

  assign hit       = (blk == BASEADDR);
  assign ridx      = idx + wcnt;
  assign last_word = (wcnt == len);
  assign good_byte = rx_done & ~rx_bad;
  assign bad_byte  = rx_done &  rx_bad;
  assign timeout   = (st == S_HDR || st == S_WDATA) && rx_st == R_IDLE && idle_cnt == TO_CYC;
  assign busy      = (st != S_IDLE) || (rx_st != R_IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nx;
  end

  // next-state decode
  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE:  if (bad_byte) st_nx = S_RECOV;
               else if (good_byte) st_nx = S_HDR;
      S_HDR:   if (bad_byte) st_nx = S_RECOV;
               else if (timeout) st_nx = S_IDLE;
               else if (good_byte && hcnt == 2'd2)
                 st_nx = !rw ? S_WDATA : (hit ? S_RESP : S_IDLE);
      S_WDATA: if (bad_byte) st_nx = S_RECOV;
               else if (timeout) st_nx = S_IDLE;
               else if (good_byte && hb && last_word) st_nx = hit ? S_ACK : S_IDLE;
      S_RESP:  if (tx_done && hb && last_word) st_nx = S_IDLE;
      S_ACK:   if (tx_done) st_nx = S_IDLE;
      S_RECOV: if (idle_cnt >= (par_mode ? BYTE_E1 : BYTE_N1)) st_nx = S_IDLE;
      default: st_nx = S_IDLE;
    endcase
  end

  // per-state outputs: receiver enable, transmit requests, register write strobe
  always_comb begin
    rx_en   = 1'b0;
    tx_go   = 1'b0;
    tx_byte = 8'h00;
    reg_we  = 1'b0;
    case (st)
      S_IDLE, S_HDR: rx_en = 1'b1;
      S_WDATA: begin
        rx_en  = 1'b1;
        reg_we = good_byte & hb & hit;
      end
      S_RESP: begin
        tx_go   = (tx_st == T_IDLE);
        tx_byte = hb ? rd_word[7:0] : regs[ridx][15:8];
      end
      S_ACK: begin
        tx_go   = (tx_st == T_IDLE);
        tx_byte = 8'h55;
      end
      default: ;
    endcase
  end

  // header capture, word/byte counters, register file, idle timer, err pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0; rw <= 1'b0; hb <= 1'b0; len <= '0; blk <= '0; idx <= '0;
      wcnt <= '0; hold <= '0; rd_word <= '0; idle_cnt <= '0; err <= 1'b0;
      par_mode <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      err <= bad_byte | timeout;
      if (st == S_IDLE && rx_st == R_IDLE) par_mode <= parity_en;
      // counts quiet cycles between bytes; in recovery only while the line is high
      if (st != st_nx || rx_st != R_IDLE || (st == S_RECOV && !rx_s)) idle_cnt <= '0;
      else if (idle_cnt != '1) idle_cnt <= idle_cnt + IW'(1);
      if (reg_we) regs[ridx] <= {hold, rx_sh};
      case (st)
        S_IDLE: if (good_byte) begin
          rw <= rx_sh[7]; len <= rx_sh[3:0];
          hcnt <= 2'd1; wcnt <= '0; hb <= 1'b0;
        end
        S_HDR: if (good_byte) begin
          hcnt <= hcnt + 2'd1;
          if (hcnt == 2'd1) blk <= rx_sh[7:4];
          else              idx <= rx_sh[3:0];
        end
        S_WDATA: if (good_byte) begin
          hb <= ~hb;
          if (!hb) hold <= rx_sh;
          else     wcnt <= wcnt + 4'd1;
        end
        S_RESP: begin
          if (tx_go && !hb) rd_word <= regs[ridx];
          if (tx_done) begin
            hb <= ~hb;
            if (hb) wcnt <= wcnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: host BFM drives rxd, a txd monitor decodes
// response bytes and checks them against a queue filled by a register model.
`timescale 1ns/1ps
module tb_uart_reg_bridge;
  localparam int         BD   = 8;
  localparam logic [3:0] BASE = 4'h2;
  localparam int         TO   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1, parity_en = 1'b0, rxd = 1'b1;
  logic txd, busy, err;

  always #5 clk = ~clk;

  uart_reg_bridge #(.BASEADDR(BASE), .BAUD_DIV(BD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .parity_en(parity_en), .rxd(rxd),
    .txd(txd), .busy(busy), .err(err)
  );

  logic [15:0] mregs [16];
  logic [15:0] wbuf  [16];
  logic [7:0]  expq [$];
  int n_vec = 0, n_bad = 0;
  int err_seen = 0, err_exp = 0, tx_bytes = 0, rst_gen = 0;
  logic mon_par = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (!rst && err === 1'b1) err_seen++;

  // txd monitor: decode every frame, compare against the scoreboard queue
  initial begin : mon
    logic [7:0] d;
    logic p, sb, eb;
    int g;
    p = 1'b0;
    forever begin
      @(negedge txd);
      g = rst_gen;
      repeat (BD / 2) @(negedge clk);
      sb = txd;
      for (int i = 0; i < 8; i++) begin repeat (BD) @(negedge clk); d[i] = txd; end
      if (mon_par) begin repeat (BD) @(negedge clk); p = txd; end
      repeat (BD) @(negedge clk);
      eb = txd;
      if (g == rst_gen) begin
        tx_bytes++;
        chk("tx_start_bit", sb, 1'b0);
        chk("tx_stop_bit", eb, 1'b1);
        if (mon_par) chk("tx_parity_bit", p, ^d);
        if (expq.size() == 0) chk("tx_unexpected_byte", {24'h0, d}, 32'h100);
        else chk("tx_byte", d, expq.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic flip);
    logic [10:0] f;
    int n;
    n = parity_en ? 11 : 10;
    f = {1'b1, parity_en ? (^b ^ flip) : 1'b1, b, 1'b0};
    for (int i = 0; i < n; i++) begin rxd = f[i]; repeat (BD) @(negedge clk); end
  endtask

  task automatic set_par(input logic p);
    parity_en = p;
    mon_par   = p;
    @(negedge clk);
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while ((expq.size() != 0 || busy) && t < 20000) begin @(negedge clk); t++; end
    chk({nm, "_completes"}, (t < 20000), 1'b1);
    repeat (2 * BD) @(negedge clk);
  endtask

  task automatic send_hdr(input logic r, input logic [15:0] a, input logic [3:0] ln);
    send_byte({r, 3'b000, ln}, 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(a[7:0], 1'b0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [3:0] ln);
    if (a[15:12] == BASE) expq.push_back(8'h55);
    send_hdr(1'b0, a, ln);
    for (int k = 0; k <= int'(ln); k++) begin
      if (a[15:12] == BASE) mregs[4'(a[3:0] + 4'(k))] = wbuf[k];
      send_byte(wbuf[k][15:8], 1'b0);
      send_byte(wbuf[k][7:0], 1'b0);
    end
    wait_done("write");
  endtask

  task automatic do_read(input logic [15:0] a, input logic [3:0] ln);
    if (a[15:12] == BASE)
      for (int k = 0; k <= int'(ln); k++) begin
        expq.push_back(mregs[4'(a[3:0] + 4'(k))][15:8]);
        expq.push_back(mregs[4'(a[3:0] + 4'(k))][7:0]);
      end
    send_hdr(1'b1, a, ln);
    if (a[15:12] == BASE) chk("busy_during_resp", busy, 1'b1);
    wait_done("read");
  endtask

  task automatic burst_pair();
    for (int k = 0; k < 15; k++) wbuf[k] = {4{4'(k + 1)}};
    wbuf[15] = 16'hABCD;
    do_write(16'h2001, 4'd15);
    do_read(16'h2001, 4'd15);
    chk("model_reg0_wrap", mregs[0], 16'hABCD);
    do_read(16'h2008, 4'd0);
  endtask

  initial begin : stim
    int t, nb;
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    repeat (4) @(negedge clk);
    chk("reset_txd", txd, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", err, 1'b0);
    rst = 1'b0;
    repeat (2 * BD) @(negedge clk);

    // single write/read, then wrapping burst, in both framing modes
    for (int pm = 0; pm < 2; pm++) begin
      set_par(1'(pm));
      wbuf[0] = 16'h8888;
      do_write(16'h2008, 4'd0);
      do_read(16'h2008, 4'd0);
      burst_pair();
    end

    // corrupted parity on the second byte of a write word: err, no write, no ack
    set_par(1'b1);
    nb = tx_bytes;
    send_hdr(1'b0, 16'h2005, 4'd0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b1);
    err_exp++;
    repeat (14 * BD) @(negedge clk);
    chk("parity_err_pulse", err_seen, err_exp);
    chk("parity_err_no_ack", tx_bytes, nb);
    chk("parity_err_idle", busy, 1'b0);
    do_read(16'h2005, 4'd0);

    // other block: data swallowed, no response, next command works
    set_par(1'b0);
    nb = tx_bytes;
    wbuf[0] = 16'h1234;
    do_write(16'h3008, 4'd0);
    do_read(16'h3008, 4'd0);
    chk("miss_no_txd", tx_bytes, nb);
    do_read(16'h2008, 4'd0);

    // inter-byte timeout: quiet just under the limit, then past it
    send_byte(8'h00, 1'b0);
    repeat ((TO - 4) * BD) @(negedge clk);
    chk("timeout_not_early", err_seen, err_exp);
    repeat (14 * BD) @(negedge clk);
    err_exp++;
    chk("timeout_err_pulse", err_seen, err_exp);
    chk("timeout_idle", busy, 1'b0);
    wbuf[0] = 16'h0F0F;
    do_write(16'h200C, 4'd0);
    do_read(16'h200C, 4'd0);

    // short low glitch on rxd is not a start bit
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BD) @(negedge clk);
    chk("glitch_busy", busy, 1'b0);
    chk("glitch_no_err", err_seen, err_exp);

    // randomized commands against the model
    for (int it = 0; it < 20; it++) begin
      logic [15:0] a;
      logic [3:0]  ln, blk;
      set_par(1'($urandom_range(0, 1)));
      blk = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : BASE;
      a   = {blk, 8'($urandom), 4'($urandom)};
      ln  = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) wbuf[k] = 16'($urandom);
        do_write(a, ln);
      end else begin
        do_read(a, ln);
      end
    end

    // reset in the middle of a burst read response
    set_par(1'b0);
    for (int k = 0; k < 16; k++) begin
      expq.push_back(mregs[k][15:8]);
      expq.push_back(mregs[k][7:0]);
    end
    send_hdr(1'b1, 16'h2000, 4'd15);
    t = 0;
    while (expq.size() > 20 && t < 20000) begin @(negedge clk); t++; end
    chk("rst_resp_started", (t < 20000), 1'b1);
    rst_gen++;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_txd", txd, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    repeat (2 * BD) @(negedge clk);
    do_read(16'h2008, 4'd0);
    do_read(16'h200F, 4'd1);

    chk("err_total", err_seen, err_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
